// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter sharing one synchronous single-port RAM
// Each access runs IDLE->ACCESS->CAPTURE->RESP with a fixed latency and a one-cycle ack.
module mem_arbiter #(
   parameter int          RAM_AW    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h10000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_wren,
   input  logic [31:0]       m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic [31:0]       m0_rdata,
   output logic              m0_ack,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_wren,
   input  logic [31:0]       m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic [31:0]       m1_rdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_wren,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   localparam logic [32:0] RANGE = 33'd4 << RAM_AW;

   state_t      state;
   logic        gnt;
   logic        last_gnt;
   logic        lat_wren;
   logic        lat_range;

   logic        sel;
   logic        sel_wren;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [31:0] sel_off;
   logic        sel_range;
   logic [31:0] cap_data;

   // The master not granted last wins a tie; a lone request always wins.
   always_comb begin
      sel       = (m0_req && m1_req) ? ~last_gnt : m1_req;
      sel_wren  = sel ? m1_wren  : m0_wren;
      sel_addr  = sel ? m1_addr  : m0_addr;
      sel_wdata = sel ? m1_wdata : m0_wdata;
      sel_off   = sel_addr - BASE_ADDR;
      sel_range = ({1'b0, sel_off} < RANGE) && (sel_off[1:0] == 2'b00);
      cap_data  = (!lat_wren && lat_range) ? ram_rdata : 32'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last_gnt  <= 1'b1;
         lat_wren  <= 1'b0;
         lat_range <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= 32'd0;
         ram_wren  <= 1'b0;
         m0_rdata  <= 32'd0;
         m0_ack    <= 1'b0;
         m0_err    <= 1'b0;
         m1_rdata  <= 32'd0;
         m1_ack    <= 1'b0;
         m1_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state     <= ACCESS;
                  gnt       <= sel;
                  last_gnt  <= sel;
                  lat_wren  <= sel_wren;
                  lat_range <= sel_range;
                  ram_addr  <= sel_off[RAM_AW+1:2];
                  ram_wdata <= sel_wdata;
                  ram_wren  <= sel_wren && sel_range;
               end
            end
            ACCESS: begin
               ram_wren <= 1'b0;
               state    <= CAPTURE;
            end
            CAPTURE: begin
               // RAM data for the address sampled at the ACCESS edge is valid now.
               state <= RESP;
               if (gnt) begin
                  m1_rdata <= cap_data;
                  m1_ack   <= 1'b1;
                  m1_err   <= ~lat_range;
               end else begin
                  m0_rdata <= cap_data;
                  m0_ack   <= 1'b1;
                  m0_err   <= ~lat_range;
               end
            end
            RESP: begin
               m0_ack <= 1'b0;
               m0_err <= 1'b0;
               m1_ack <= 1'b0;
               m1_err <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
